// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam int DATA_BITS = 8;

  // Serial bits per frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return 1 + DATA_BITS + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - clocks-per-bit counter with clear and end-of-bit pulse
module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1; a clear restarts the bit period for the new state.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains an 8-bit FIFO and sends each byte as a UART frame
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] tx_count
);

  localparam logic ODD = (PARITY_ODD != 0);

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shreg, sh_next;
  logic [2:0]           bit_cnt;
  logic                 par_bit;
  logic                 tx_next;
  logic                 bit_end;
  logic                 state_change;

  assign state_change = (state_next != state);
  assign busy         = (state != IDLE);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_change),
    .bit_end (bit_end)
  );

  // Next state, FIFO pop strobe and next shift-register contents.
  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    sh_next    = shreg;
    case (state)
      IDLE: begin
        // Pops are suppressed while reset is held so no byte is lost in reset.
        if (rst_n && enable && !fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        sh_next    = fifo_data;
        state_next = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          sh_next = {1'b0, shreg[DATA_BITS-1:1]};
          if (bit_cnt == 3'd7) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end && ((STOP_BITS == 1) || (bit_cnt == 3'd1))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = sh_next[0];
      PARITY:  tx_next = par_bit;
      default: tx_next = 1'b1;
    endcase
  end

  // State, shift data, registered line and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      tx_count   <= 16'd0;
    end else begin
      state      <= state_next;
      shreg      <= sh_next;
      tx         <= tx_next;
      frame_done <= (state == STOP) && (state_next == IDLE);
      if (state == LOAD) par_bit <= (^fifo_data) ^ ODD;
      if ((state == STOP) && (state_next == IDLE)) tx_count <= tx_count + 16'd1;
    end
  end

  // Bit index within DATA and STOP; restarts whenever the state changes.
  always_ff @(posedge clk) begin
    if (!rst_n || state_change) begin
      bit_cnt <= 3'd0;
    end else if (bit_end && ((state == DATA) || (state == STOP))) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx against a frame-level model
module tb_fifo_uart_tx;

  localparam int NDUT = 3;
  localparam int CPB [NDUT] = '{4, 4, 3};
  localparam int PEN [NDUT] = '{0, 1, 1};
  localparam int POD [NDUT] = '{0, 0, 1};
  localparam int SB  [NDUT] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en;
  logic [2:0]  empty;
  logic [7:0]  data [NDUT];
  logic [2:0]  rd, tx, busy, fd;
  logic [15:0] cnt [NDUT];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(empty[0]), .fifo_data(data[0]),
    .fifo_rd(rd[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]), .tx_count(cnt[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(empty[1]), .fifo_data(data[1]),
    .fifo_rd(rd[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]), .tx_count(cnt[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo_empty(empty[2]), .fifo_data(data[2]),
    .fifo_rd(rd[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fd[2]), .tx_count(cnt[2]));

  logic [7:0]  q        [NDUT][$];
  logic        exp_tx_q [NDUT][$];
  int          fd_q     [NDUT][$];
  int          busy_until [NDUT];
  logic [15:0] exp_cnt  [NDUT];
  logic        pend     [NDUT];
  int          rd_seen  [NDUT];
  int          last_rd  [NDUT];
  int          prev_rd  [NDUT];
  int          last_fd  [NDUT];
  int          cyc_n;
  bit          chk;
  int          n_assert;
  int          n_fail;

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d] cycle %0d: observed %0h expected %0h", tag, i, cyc_n, obs, expv);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    q[i].push_back(b);
    empty[i] = 1'b0;
  endtask

  // Expected line for a byte popped in cycle t: LOAD cycle high, then the frame.
  task automatic sched(input int i, input logic [7:0] b, input int t);
    logic fr [$];
    fr.push_back(1'b0);
    for (int k = 0; k < 8; k++) fr.push_back(b[k]);
    if (PEN[i] != 0) fr.push_back((^b) ^ (POD[i] != 0));
    for (int s = 0; s < SB[i]; s++) fr.push_back(1'b1);
    exp_tx_q[i].push_back(1'b1);
    foreach (fr[k]) repeat (CPB[i]) exp_tx_q[i].push_back(fr[k]);
    busy_until[i] = t + 2 + fr.size() * CPB[i];
    fd_q[i].push_back(busy_until[i]);
  endtask

  // One clock: compare at the falling edge, update the FIFO models after the rising edge.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      logic efd, ebusy, erd, etx;
      efd = 1'b0;
      if (fd_q[i].size() > 0 && fd_q[i][0] == cyc_n) begin
        efd = 1'b1;
        void'(fd_q[i].pop_front());
        exp_cnt[i] = exp_cnt[i] + 16'd1;
      end
      ebusy = (cyc_n < busy_until[i]);
      erd   = rst_n && en[i] && !empty[i] && !ebusy;
      etx   = (exp_tx_q[i].size() > 0) ? exp_tx_q[i].pop_front() : 1'b1;
      if (chk) begin
        check("fifo_rd",    i, 32'(rd[i]),   32'(erd));
        check("busy",       i, 32'(busy[i]), 32'(ebusy));
        check("tx",         i, 32'(tx[i]),   32'(etx));
        check("frame_done", i, 32'(fd[i]),   32'(efd));
        check("tx_count",   i, 32'(cnt[i]),  32'(exp_cnt[i]));
      end
      if (erd) sched(i, q[i][0], cyc_n);
      pend[i] = (rd[i] === 1'b1);
      if (rd[i] === 1'b1) begin
        rd_seen[i]++;
        prev_rd[i] = last_rd[i];
        last_rd[i] = cyc_n;
      end
      if (fd[i] === 1'b1) last_fd[i] = cyc_n;
      if (!rst_n) begin
        exp_tx_q[i].delete();
        fd_q[i].delete();
        busy_until[i] = 0;
        exp_cnt[i]    = 16'd0;
      end
    end
    if (!rst_n) chk = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < NDUT; i++) begin
      if (pend[i] && q[i].size() > 0) data[i] = q[i].pop_front();
      empty[i] = (q[i].size() == 0);
    end
  endtask

  task automatic wait_pop0(input string tag);
    int r0;
    int k;
    r0 = rd_seen[0];
    k  = 0;
    while (rd_seen[0] == r0 && k < 60) begin
      cyc();
      k++;
    end
    check(tag, 0, rd_seen[0] - r0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc_n    = 0;
    chk      = 1'b0;
    rst_n    = 1'b0;
    en       = 3'b000;
    empty    = 3'b111;
    for (int i = 0; i < NDUT; i++) begin
      data[i] = 8'h00;
      busy_until[i] = 0;
      exp_cnt[i] = 16'd0;
      pend[i] = 1'b0;
      rd_seen[i] = 0;
      last_rd[i] = 0;
      prev_rd[i] = 0;
      last_fd[i] = 0;
    end

    // Reset
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single byte per channel: 0xA5 plain, 0x07 with even and odd parity
    push(0, 8'hA5);
    push(1, 8'h07);
    push(2, 8'h07);
    en = 3'b111;
    repeat (60) cyc();
    check("single_pops",    0, rd_seen[0], 1);
    check("single_latency", 0, last_fd[0] - last_rd[0], 42);
    check("single_count",   0, 32'(cnt[0]), 1);
    check("even_latency",   1, last_fd[1] - last_rd[1], 46);
    check("odd_latency",    2, last_fd[2] - last_rd[2], 38);

    // Back-to-back 0x00 then 0xFF
    push(0, 8'h00);
    push(0, 8'hFF);
    repeat (100) cyc();
    check("b2b_spacing", 0, last_rd[0] - prev_rd[0], 42);
    check("b2b_count",   0, 32'(cnt[0]), 3);

    // Enable low with data waiting: no pops
    en = 3'b000;
    for (int i = 0; i < NDUT; i++) begin
      push(i, 8'($urandom));
      push(i, 8'($urandom));
    end
    begin
      int base [NDUT];
      for (int i = 0; i < NDUT; i++) base[i] = rd_seen[i];
      repeat (100) cyc();
      for (int i = 0; i < NDUT; i++) check("gated_pops", i, rd_seen[i] - base[i], 0);
    end

    // Enable dropped during DATA: frame completes, no further pop
    en = 3'b111;
    wait_pop0("drop_pop");
    repeat (8) cyc();
    en = 3'b000;
    begin
      int r0;
      r0 = rd_seen[0];
      repeat (80) cyc();
      check("drop_no_pop", 0, rd_seen[0] - r0, 0);
      check("drop_done",   0, last_fd[0] - last_rd[0], 42);
    end

    // Randomised traffic with enable toggling
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) begin
        int i;
        i = int'($urandom_range(NDUT - 1));
        if (q[i].size() < 4) push(i, 8'($urandom));
      end
      if ($urandom_range(29) == 0) en = 3'($urandom);
      cyc();
    end
    en = 3'b111;
    repeat (250) cyc();

    // Reset during data bit 3, then immediate re-pop
    push(0, 8'h3C);
    push(0, 8'h5A);
    wait_pop0("rst_pop");
    repeat (18) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_repop",  0, last_rd[0], cyc_n - 1);
    check("rst_count",  0, 32'(cnt[0]), 0);
    repeat (120) cyc();

    // Two-cycle reset during a frame on every channel
    for (int i = 0; i < NDUT; i++) push(i, 8'($urandom));
    repeat (20) cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < NDUT; i++) begin
      check("rst2_tx",    i, 32'(tx[i]),   1);
      check("rst2_busy",  i, 32'(busy[i]), 0);
      check("rst2_rd",    i, 32'(rd[i]),   0);
      check("rst2_done",  i, 32'(fd[i]),   0);
      check("rst2_count", i, 32'(cnt[i]),  0);
    end
    rst_n = 1'b1;
    repeat (150) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
